// File: rtl/opera_bus_router.sv
// Wishbone-classic router from the ZAP CPU master to N address-decoded slave regions.
// It registers the read data, issues one ack per access, and adds a bus timeout with error capture.
module opera_bus_router #(
    parameter int                        NUM_REGIONS  = 4,
    parameter int                        DATA_W       = 32,
    parameter logic [32*NUM_REGIONS-1:0] REGION_BASE  = '0,
    parameter logic [32*NUM_REGIONS-1:0] REGION_MASK  = '0,
    parameter logic [NUM_REGIONS-1:0]    ACK_INTERNAL = '0,
    parameter logic [4*NUM_REGIONS-1:0]  WAIT_CYCLES  = '0,
    parameter int                        TIMEOUT      = 64,
    parameter logic [DATA_W-1:0]         ERR_DATA     = DATA_W'(32'hBADB_ADBA)
) (
    input  logic                          sys_clk,
    input  logic                          reset_n,
    input  logic                          m_cyc,
    input  logic                          m_stb,
    input  logic                          m_we,
    input  logic [31:0]                   m_adr,
    input  logic [DATA_W-1:0]             m_dat_i,
    input  logic [3:0]                    m_sel,
    output logic [DATA_W-1:0]             m_dat_o,
    output logic                          m_ack,
    output logic                          m_err,
    output logic [NUM_REGIONS-1:0]        s_stb,
    output logic                          s_we,
    output logic [31:0]                   s_adr,
    output logic [DATA_W-1:0]             s_dat_o,
    output logic [3:0]                    s_sel,
    input  logic [NUM_REGIONS*DATA_W-1:0] s_dat_i,
    input  logic [NUM_REGIONS-1:0]        s_ack,
    output logic                          busy,
    output logic [31:0]                   err_addr,
    output logic [7:0]                    err_count
);
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int CNT_W = (TIMEOUT > 16) ? $clog2(TIMEOUT) : 4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  hit_idx;
    logic              hit;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  hit_cnt;
    logic              err_flag;
    logic              sel_int;
    logic              sel_ack;
    logic [DATA_W-1:0] sel_dat;
    logic              accept;
    logic              finish;
    logic              finish_err;
    logic              cnt_dec;

    // Scanning downward lets the lowest-index hit overwrite higher ones on overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_cnt = CNT_W'(TIMEOUT - 1);
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((m_adr & REGION_MASK[32*i +: 32]) == REGION_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                hit_cnt = ACK_INTERNAL[i] ? CNT_W'(WAIT_CYCLES[4*i +: 4]) : CNT_W'(TIMEOUT - 1);
            end
        end
    end

    always_comb begin
        sel_int = 1'b0;
        sel_ack = 1'b0;
        sel_dat = '0;
        s_stb   = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_int  = ACK_INTERNAL[i];
                sel_ack  = s_ack[i];
                sel_dat  = s_dat_i[DATA_W*i +: DATA_W];
                s_stb[i] = (state == ACCESS);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // A master abort takes priority over a completion arriving in the same cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        finish_err = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (m_cyc && m_stb) begin
                    accept     = 1'b1;
                    state_next = hit ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (!m_cyc) begin
                    state_next = IDLE;
                end else if (sel_int ? (cnt == '0) : sel_ack) begin
                    finish     = 1'b1;
                    state_next = RESP;
                end else if (!sel_int && (cnt == '0)) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            cnt       <= '0;
            err_flag  <= 1'b0;
            m_dat_o   <= '0;
            s_we      <= 1'b0;
            s_adr     <= '0;
            s_dat_o   <= '0;
            s_sel     <= '0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            if (accept) begin
                s_we     <= m_we;
                s_adr    <= m_adr;
                s_dat_o  <= m_dat_i;
                s_sel    <= m_sel;
                idx      <= hit_idx;
                cnt      <= hit_cnt;
                err_flag <= !hit;
                if (!hit) m_dat_o <= ERR_DATA;
            end
            if (cnt_dec) cnt <= cnt - 1'b1;
            if (finish) begin
                err_flag <= finish_err;
                m_dat_o  <= finish_err ? ERR_DATA : sel_dat;
            end
            if (state == RESP && err_flag) begin
                err_addr <= s_adr;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

    assign m_ack = (state == RESP) && !err_flag;
    assign m_err = (state == RESP) && err_flag;
    assign busy  = (state != IDLE);
endmodule

// File: tb/tb_opera_bus_router.sv
// Scoreboarded bench for opera_bus_router: four regions mixing internal and external acks,
// an overlapping decode pair, unmapped accesses, timeouts, master aborts and reset mid-access.
module tb_opera_bus_router;
  localparam int N = 4;
  localparam int W = 32;

  logic           sys_clk;
  logic           reset_n;
  logic           m_cyc, m_stb, m_we;
  logic [31:0]    m_adr;
  logic [W-1:0]   m_dat_i;
  logic [3:0]     m_sel;
  logic [W-1:0]   m_dat_o;
  logic           m_ack, m_err;
  logic [N-1:0]   s_stb;
  logic           s_we;
  logic [31:0]    s_adr;
  logic [W-1:0]   s_dat_o;
  logic [3:0]     s_sel;
  logic [N*W-1:0] s_dat_i;
  logic [N-1:0]   s_ack;
  logic           busy;
  logic [31:0]    err_addr;
  logic [7:0]     err_count;

  opera_bus_router #(
    .NUM_REGIONS (N),
    .DATA_W      (W),
    .REGION_BASE ({32'h0100_0000, 32'h0340_0000, 32'h0340_0400, 32'h0000_0000}),
    .REGION_MASK ({32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_FF00, 32'hFF00_0000}),
    .ACK_INTERNAL(4'b1001),
    .WAIT_CYCLES ({4'd0, 4'd0, 4'd0, 4'd3}),
    .TIMEOUT     (8),
    .ERR_DATA    (32'hBADB_ADBA)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_i(m_dat_i), .m_sel(m_sel), .m_dat_o(m_dat_o),
    .m_ack(m_ack), .m_err(m_err),
    .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o), .s_sel(s_sel),
    .s_dat_i(s_dat_i), .s_ack(s_ack),
    .busy(busy), .err_addr(err_addr), .err_count(err_count)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- slave models ----------------
  logic [31:0] rdat [N];
  int          ack_dly [N];
  int          stb_age [N];
  logic [N-1:0] stray_ack;

  always_comb begin
    s_dat_i = '0;
    s_ack   = '0;
    for (int i = 0; i < N; i++) begin
      s_dat_i[W*i +: W] = rdat[i];
      s_ack[i] = (s_stb[i] && ack_dly[i] >= 0 && stb_age[i] == ack_dly[i]) || stray_ack[i];
    end
  end

  always @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) stb_age[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) stb_age[i] <= s_stb[i] ? stb_age[i] + 1 : 0;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // entry = {check_data, is_err, data[31:0], resp_cycle[31:0]}
  logic [65:0] exp_q[$];
  logic [65:0] item;

  always @(negedge sys_clk) begin
    if (reset_n && (m_ack || m_err)) begin
      check("ack_err_exclusive", 32'(m_ack & m_err), 32'd0);
      check("stb_at_resp", 32'(s_stb), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        item = exp_q.pop_front();
        check("resp_kind", 32'(m_err), 32'(item[64]));
        check("resp_cycle", 32'(cyc), item[31:0]);
        if (item[65]) check("resp_data", m_dat_o, item[63:32]);
      end
    end
  end

  // ---------------- driver ----------------
  int          stb_first, stb_last;
  logic [N-1:0] stb_seen;
  int          exp_errs = 0;

  task automatic access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic is_err, input logic chk_dat,
                        input logic [31:0] exp_dat, input int lat);
    int t0;
    bit done;
    @(negedge sys_clk);
    t0 = cyc;
    exp_q.push_back({chk_dat, is_err, exp_dat, 32'(t0 + lat)});
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat_i = dat; m_sel = sel;
    stb_first = -1; stb_last = -1; stb_seen = '0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge sys_clk);
      if (s_stb != '0) begin
        if (stb_first < 0) stb_first = cyc - t0;
        stb_last = cyc - t0;
        stb_seen |= s_stb;
      end
      if (m_ack || m_err) done = 1'b1;
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    if (!done) begin
      check("no_response", 32'd0, 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (is_err && exp_errs < 255) exp_errs++;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] a;
  logic [31:0] d;

  initial begin
    reset_n = 1'b0;
    m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_dat_i = '0; m_sel = '0;
    stray_ack = '0;
    rdat[0] = 32'h1234_5678;
    for (int i = 1; i < N; i++) rdat[i] = $urandom;
    for (int i = 0; i < N; i++) ack_dly[i] = -1;
    repeat (3) @(negedge sys_clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp", 32'({m_ack, m_err}), 32'd0);
    check("rst_stb", 32'(s_stb), 32'd0);
    check("rst_dat_o", m_dat_o, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    reset_n = 1'b1;

    // Internal region 0, WAIT=3; stray acks must not shorten it.
    stray_ack = 4'b1111;
    a = {8'h00, 24'($urandom)};
    access(a, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, rdat[0], 5);
    stray_ack = '0;
    check("int_stb_first", 32'(stb_first), 32'd1);
    check("int_stb_last", 32'(stb_last), 32'd4);
    check("int_stb_onehot", 32'(stb_seen), 32'b0001);

    // Internal region 3, WAIT=0.
    a = {8'h01, 24'($urandom)};
    access(a, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, rdat[3], 2);
    check("int0_stb", 32'(stb_seen), 32'b1000);

    // External region 1 write, slave acks 2 cycles after strobe.
    ack_dly[1] = 2;
    access(32'h0340_0408, 1'b1, 32'hCAFE_F00D, 4'b0011, 1'b0, 1'b0, 32'h0, 4);
    check("wr_s_we", 32'(s_we), 32'd1);
    check("wr_s_sel", 32'(s_sel), 32'b0011);
    check("wr_s_dat_o", s_dat_o, 32'hCAFE_F00D);
    check("wr_s_adr", s_adr, 32'h0340_0408);
    access({24'h034004, 8'($urandom)}, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, rdat[1], 4);

    // Overlap: region1 wins over region2; ack in the first strobe cycle.
    ack_dly[1] = 0;
    access(32'h0340_0414, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, rdat[1], 2);
    check("overlap_stb", 32'(stb_seen), 32'b0010);
    ack_dly[1] = 1;
    access(32'h0340_0414, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, rdat[1], 3);

    // Region2 random-delay reads.
    for (int n = 0; n < 4; n++) begin
      ack_dly[2] = $urandom_range(0, 6);
      a = {16'h0340, 4'($urandom_range(1, 15)), 12'($urandom)};
      access(a, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, rdat[2], ack_dly[2] + 2);
    end
    ack_dly[2] = -1;

    // Unmapped.
    access(32'h0500_0000, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1, 32'hBADB_ADBA, 1);
    check("unmapped_stb", 32'(stb_seen), 32'd0);
    @(negedge sys_clk);
    check("unmapped_err_addr", err_addr, 32'h0500_0000);
    check("unmapped_err_count", 32'(err_count), 32'(exp_errs));

    // Timeout on region2 with stray acks on every other region.
    stray_ack = 4'b1011;
    a = {16'h0340, 4'h1, 12'($urandom)};
    access(a, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1, 32'hBADB_ADBA, 9);
    stray_ack = '0;
    check("tmo_stb_last", 32'(stb_last), 32'd8);
    @(negedge sys_clk);
    check("tmo_err_addr", err_addr, a);
    check("tmo_err_count", 32'(err_count), 32'(exp_errs));

    // Master abort at T+2.
    @(negedge sys_clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0340_2000;
    @(negedge sys_clk);
    check("abort_busy", 32'(busy), 32'd1);
    @(negedge sys_clk);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge sys_clk);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_stb", 32'(s_stb), 32'd0);
    repeat (10) @(negedge sys_clk);
    check("abort_err_count", 32'(err_count), 32'(exp_errs));
    access({8'h00, 24'($urandom)}, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, rdat[0], 5);

    // Saturation: 300 errors in total.
    for (int n = 0; n < 298; n++) begin
      access({16'h0340, 4'h2, 12'($urandom)}, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 9);
    end
    @(negedge sys_clk);
    check("err_count_sat", 32'(err_count), 32'(exp_errs));
    check("err_count_ff", 32'(err_count), 32'hFF);

    // Reset pulse in ACCESS.
    @(negedge sys_clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h0340_3000;
    m_dat_i = 32'h5555_AAAA; m_sel = 4'hF;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_stb", 32'(s_stb), 32'd0);
    check("rstmid_adr", s_adr, 32'd0);
    check("rstmid_ctl", 32'({s_we, s_sel}), 32'd0);
    check("rstmid_wdat", s_dat_o, 32'd0);
    check("rstmid_err_count", 32'(err_count), 32'd0);
    check("rstmid_err_addr", err_addr, 32'd0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge sys_clk);
    reset_n = 1'b1;
    exp_errs = 0;
    access({8'h01, 24'($urandom)}, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, rdat[3], 2);
    repeat (2) @(negedge sys_clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
